// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the EX-stage pipeline and mult_div_unit.
// master: pipeline side (drives requests, mthi/mtlo writes and the read select).
// slave : the unit (drives busy, done and the HI/LO read data).
//   start   request an operation (sampled only when busy=0)
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   input1  multiplicand / dividend
//   input2  multiplier / divisor
//   hi_we   write wdata into HI (mthi)
//   lo_we   write wdata into LO (mtlo)
//   wdata   data for hi_we/lo_we
//   hi_lo   read select: 1 = HI, 0 = LO
//   busy    operation in progress
//   done    one-cycle pulse when HI/LO receive a new result
//   data    hi_lo ? HI : LO (combinational)
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             hi_lo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data;

  modport master (
    output start, op, input1, input2, hi_we, lo_we, wdata, hi_lo,
    input  busy, done, data
  );

  modport slave (
    input  start, op, input1, input2, hi_we, lo_we, wdata, hi_lo,
    output busy, done, data
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, with sign correction in a final cycle. Fixed latency of WIDTH+1 cycles.
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   bus_io  mult_div_unit_if slave modport (start/op/operands, mthi/mtlo
//           writes, read select, busy/done/data)
module mult_div_unit #(
  parameter int unsigned  WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic             clk,
  input logic             rst,
  mult_div_unit_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;          // negate product / quotient
  logic             rem_neg_q, rem_neg_d;  // negate remainder (dividend sign)
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] a_q, a_d;              // multiplicand, or dividend -> quotient
  logic [WIDTH-1:0] b_q, b_d;              // multiplier -> product low, or divisor
  logic [WIDTH-1:0] acc_q, acc_d;          // product high, or partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand magnitudes for signed ops (op[0]=0 means signed).
  logic             sign1, sign2;
  logic [WIDTH-1:0] abs1, abs2;
  assign sign1 = ~bus_io.op[0] & bus_io.input1[WIDTH-1];
  assign sign2 = ~bus_io.op[0] & bus_io.input2[WIDTH-1];
  assign abs1  = sign1 ? -bus_io.input1 : bus_io.input1;
  assign abs2  = sign2 ? -bus_io.input2 : bus_io.input2;

  // Multiply step: conditionally add, then shift {carry, acc, b} right.
  logic [WIDTH:0] add_sum;
  assign add_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);

  // Divide step: shift next dividend bit into the remainder and trial-subtract.
  logic [WIDTH:0] trial, rem_next;
  logic           ge;
  assign trial    = {acc_q, a_q[WIDTH-1]};
  assign ge       = (trial >= {1'b0, b_q});
  assign rem_next = ge ? (trial - {1'b0, b_q}) : trial;

  // Sign correction applied in the final cycle.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {acc_q, b_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = div0_q ? '1 : (neg_q ? -a_q : a_q);
  // With a zero divisor the remainder holds |input1|, so this restores input1.
  assign rem_fix  = rem_neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus_io.hi_we) hi_d = bus_io.wdata;
        if (bus_io.lo_we) lo_d = bus_io.wdata;
        if (bus_io.start) begin
          is_div_d  = bus_io.op[1];
          neg_d     = sign1 ^ sign2;
          rem_neg_d = sign1 & bus_io.op[1];
          div0_d    = (bus_io.input2 == '0);
          a_d       = abs1;
          b_d       = abs2;
          acc_d     = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          acc_d = rem_next[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], ge};
        end else begin
          acc_d = add_sum[WIDTH:1];
          b_d   = {add_sum[0], b_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus_io.busy = (state_q != StIdle);
  assign bus_io.done = done_q;
  assign bus_io.data = bus_io.hi_lo ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a cycle-level behavioural model built
// from plain 64-bit arithmetic, a per-cycle compare process, directed cases
// with literal expectations, and a randomized phase.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of one operation.
  function automatic void model_op(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] hi,
                                   output logic [W-1:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00) begin
      p = 64'(sa * sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == 2'b01) begin
      p = {32'b0, a} * {32'b0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
    end else if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      p = 64'(q);
      lo = p[31:0];
      p = 64'(r);
      hi = p[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Model state: HI/LO, cycles left in the current operation, pending result.
  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  int           m_rem = 0;
  bit           m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = r_hi;
          m_lo = r_lo;
          m_done = 1'b1;
        end
      end else begin
        if (bus.hi_we) m_hi = bus.wdata;
        if (bus.lo_we) m_lo = bus.wdata;
        if (bus.start) begin
          model_op(bus.op, bus.input1, bus.input2, r_hi, r_lo);
          m_rem = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", W'(bus.busy), W'(m_rem > 0));
      check("done", W'(bus.done), W'(m_done));
      check("data", bus.data, bus.hi_lo ? m_hi : m_lo);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic read_hilo(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    bus.hi_lo = 1'b1;
    #1 check({name, " HI"}, bus.data, ehi);
    bus.hi_lo = 1'b0;
    #1 check({name, " LO"}, bus.data, elo);
  endtask

  // Issue an op from idle, wait for done and compare against literals.
  // Returns in the done cycle, so consecutive calls exercise back-to-back starts.
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo);
    int n;
    bus.op = op; bus.input1 = a; bus.input2 = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.input1 = W'($urandom);
    bus.input2 = W'($urandom);
    wait_done(n);
    check({name, " latency"}, W'(n), W'(W + 1));
    read_hilo(name, ehi, elo);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7fff_ffff;
      5:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.input1 = '0; bus.input2 = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.hi_lo = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("reset busy", W'(bus.busy), '0);
    check("reset done", W'(bus.done), '0);
    read_hilo("reset", '0, '0);
    rst = 1'b0;
    tick();

    // Directed results, issued back-to-back in each done cycle.
    run_op("mult -1*7",   2'b00, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_op("multu -1*7",  2'b01, 32'hFFFF_FFFF, 32'h7, 32'h0000_0006, 32'hFFFF_FFF9);
    run_op("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 100/7",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu by 0",   2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("div -9/0",    2'b10, 32'hFFFF_FFF7, 32'h0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_op("multu 2*3",   2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
    tick();

    // mthi/mtlo from idle.
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h55;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    read_hilo("mtlo", 32'h55, 32'h55);

    // start and lo_we while busy are ignored.
    bus.op = 2'b00; bus.input1 = 32'd3; bus.input2 = 32'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1; bus.op = 2'b11; bus.input1 = 32'd9; bus.input2 = 32'd2;
    bus.lo_we = 1'b1; bus.wdata = 32'hAA;
    tick();
    bus.start = 1'b0; bus.lo_we = 1'b0;
    bus.hi_lo = 1'b0;
    #1 check("old LO while busy", bus.data, 32'h55);
    wait_done(n);
    check("busy-ignore latency", W'(10 + n), W'(W + 1));
    read_hilo("mult 3*5", 32'd0, 32'd15);
    tick();

    // Reset in the middle of a divide.
    bus.op = 2'b10; bus.input1 = 32'hFFFF_FF9C; bus.input2 = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", W'(bus.busy), '0);
    check("abort done", W'(bus.done), '0);
    read_hilo("abort", '0, '0);
    run_op("after abort", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    tick();

    // Randomized traffic, including starts while busy and writes with start.
    for (int i = 0; i < 3000; i++) begin
      bus.start  = ($urandom_range(0, 9) < 3);
      bus.op     = 2'($urandom_range(0, 3));
      bus.input1 = rnd_val();
      bus.input2 = rnd_val();
      bus.hi_we  = ($urandom_range(0, 9) == 0);
      bus.lo_we  = ($urandom_range(0, 9) == 0);
      bus.wdata  = W'($urandom);
      bus.hi_lo  = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
